// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the HUB75 BCM scan scheduler.
//   - one-hot state encodings S_IDLE .. S_DRAIN (ST_W bits)
//   - PANEL_COLS: columns shifted by the row shifter per request
//   - plane_time(base, p): display cycles of bit plane p (base << p)
package led_pkg;

   localparam int ST_W = 7;

   localparam logic [ST_W-1:0] S_IDLE    = 7'b0000001;
   localparam logic [ST_W-1:0] S_SHIFT   = 7'b0000010;
   localparam logic [ST_W-1:0] S_WAIT    = 7'b0000100;
   localparam logic [ST_W-1:0] S_BLANK   = 7'b0001000;
   localparam logic [ST_W-1:0] S_LATCH   = 7'b0010000;
   localparam logic [ST_W-1:0] S_UNBLANK = 7'b0100000;
   localparam logic [ST_W-1:0] S_DRAIN   = 7'b1000000;

   localparam int PANEL_COLS = 64;

   // Binary weight of a bit plane: the LSB plane shows for base cycles,
   // every higher plane doubles that.
   function automatic logic [31:0] plane_time(input logic [31:0] base,
                                              input int unsigned p);
      return base << p;
   endfunction

endpackage

// File: rtl/led_bcm_timer.sv
// led_bcm_timer: display-time down-counter for one BCM slot.
// Optional feature macro: LED_BCM_SCHEDULER_BRIGHTNESS_EN (adds brightness
// input and an early end-of-display compare).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         load load_val into the counter this cycle
//   load_val     display cycles of the plane about to be shown
//   brightness   (feature only) 8-bit global brightness, sampled at load
//   done         counter is zero: the slot's display time has elapsed
//   expire       display window over: blank may rise (equals done when the
//                brightness feature is off)
module led_bcm_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
`ifdef LED_BCM_SCHEDULER_BRIGHTNESS_EN
   input  logic [7:0]       brightness,
`endif
   output logic             done,
   output logic             expire
);

   logic [CNT_W-1:0] disp_cnt;

`ifdef LED_BCM_SCHEDULER_BRIGHTNESS_EN
   // on_len = (T * (brightness+1)) >> 8, never below one cycle. The counter
   // still runs the full T so the slot length is unchanged; only the lit
   // window shrinks. thresh is the counter value at which on_len cycles of
   // display have elapsed.
   logic [CNT_W+8:0] scaled;
   logic [CNT_W-1:0] on_len;
   logic [CNT_W-1:0] thresh;

   always_comb begin
      scaled = (CNT_W+9)'(load_val) * (CNT_W+9)'(brightness)
             + (CNT_W+9)'(load_val);
      on_len = CNT_W'(scaled >> 8);
      if (on_len == '0) on_len = CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_cnt <= '0;
         thresh   <= '0;
      end else if (load) begin
         disp_cnt <= load_val;
         thresh   <= load_val - on_len;
      end else if (disp_cnt != '0) begin
         disp_cnt <= disp_cnt - CNT_W'(1);
      end
   end

   assign expire = (disp_cnt <= thresh);
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_cnt <= '0;
      end else if (load) begin
         disp_cnt <= load_val;
      end else if (disp_cnt != '0) begin
         disp_cnt <= disp_cnt - CNT_W'(1);
      end
   end

   assign expire = (disp_cnt == '0);
`endif

   assign done = (disp_cnt == '0);

endmodule

// File: rtl/led_bcm_scheduler.sv
// led_bcm_scheduler: HUB75 scan sequencer for binary-coded modulation.
// Walks every (row, plane) pair, plane fastest. For each pair it requests a
// column shift, then blanks, latches and readdresses the panel, then shows
// the plane for BASE_CYCLES<<plane cycles while the next plane is shifted.
// Optional feature macro: LED_BCM_SCHEDULER_BRIGHTNESS_EN (brightness port,
// shortens the lit part of every slot).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   enable       run the scan; low -> finish current slot and idle blanked
//   shift_req    request to shift row shift_row / plane shift_plane
//   shift_done   one-cycle pulse from the shifter, counted only while
//                shift_req is high (including its first cycle)
//   shift_row    row being shifted
//   shift_plane  plane being shifted (during S_LATCH: plane being latched)
//   led_addr     panel row address, changes only when entering S_LATCH
//   led_blank    panel blank/OE, active high
//   led_latch    panel latch strobe, high for the S_LATCH cycle
//   frame_tick   one-cycle pulse after the last (row, plane) is latched
//   brightness   (feature only) 8-bit global brightness
//   state        one-hot FSM state, debug visibility
// Handshake: shift_req rises when entering S_SHIFT and stays high until a
// cycle in which shift_done is high; it drops on the following edge. It is
// never withdrawn otherwise (reset excepted), and shift_done seen while
// shift_req is low has no effect.
module led_bcm_scheduler
   import led_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int PLANES      = 8,
   parameter int BASE_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   output logic                       shift_req,
   input  logic                       shift_done,
   output logic [ADDR_W-1:0]          shift_row,
   output logic [$clog2(PLANES)-1:0]  shift_plane,
   output logic [ADDR_W-1:0]          led_addr,
   output logic                       led_blank,
   output logic                       led_latch,
   output logic                       frame_tick,
`ifdef LED_BCM_SCHEDULER_BRIGHTNESS_EN
   input  logic [7:0]                 brightness,
`endif
   output logic [ST_W-1:0]            state
);

   localparam int PLANE_W = $clog2(PLANES);

   logic [ST_W-1:0]    next_state;

   logic               disp_done;
   logic               disp_expire;
   logic               load_cnt;
   logic [CNT_W-1:0]   load_val;

   logic               shift_req_nx;
   logic [ADDR_W-1:0]  shift_row_nx;
   logic [PLANE_W-1:0] shift_plane_nx;
   logic [ADDR_W-1:0]  led_addr_nx;
   logic               led_blank_nx;
   logic               led_latch_nx;
   logic               frame_tick_nx;

   // The counter is loaded on the LATCH->UNBLANK edge, so it already holds
   // the plane's full time during S_UNBLANK and reaches zero exactly
   // T cycles later: display lasts T cycles and a slot is max(T, shift)+3.
   assign load_val = CNT_W'(plane_time(32'(BASE_CYCLES), 32'(shift_plane)));

   led_bcm_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load_cnt),
      .load_val   (load_val),
`ifdef LED_BCM_SCHEDULER_BRIGHTNESS_EN
      .brightness (brightness),
`endif
      .done       (disp_done),
      .expire     (disp_expire)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         shift_req   <= 1'b0;
         shift_row   <= '0;
         shift_plane <= '0;
         led_addr    <= '0;
         led_blank   <= 1'b1;
         led_latch   <= 1'b0;
         frame_tick  <= 1'b0;
      end else begin
         state       <= next_state;
         shift_req   <= shift_req_nx;
         shift_row   <= shift_row_nx;
         shift_plane <= shift_plane_nx;
         led_addr    <= led_addr_nx;
         led_blank   <= led_blank_nx;
         led_latch   <= led_latch_nx;
         frame_tick  <= frame_tick_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (enable) next_state = S_SHIFT;
         end
         S_SHIFT: begin
            // shift_req is always high in this state, so shift_done here
            // is a valid handshake.
            if (shift_done) next_state = disp_done ? S_BLANK : S_WAIT;
         end
         S_WAIT: begin
            if (disp_done) next_state = S_BLANK;
         end
         S_BLANK: begin
            next_state = S_LATCH;
         end
         S_LATCH: begin
            next_state = S_UNBLANK;
         end
         S_UNBLANK: begin
            next_state = enable ? S_SHIFT : S_DRAIN;
         end
         S_DRAIN: begin
            if (disp_done) next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Output logic: next values of the registered outputs.
   always_comb begin
      shift_req_nx   = (next_state == S_SHIFT);
      led_latch_nx   = (next_state == S_LATCH);
      led_addr_nx    = led_addr;
      led_blank_nx   = led_blank;
      shift_row_nx   = shift_row;
      shift_plane_nx = shift_plane;
      frame_tick_nx  = 1'b0;
      load_cnt       = 1'b0;

      // Address moves together with the latch strobe.
      if (next_state == S_LATCH) led_addr_nx = shift_row;

      case (state)
         S_LATCH: begin
            // shift_plane still names the plane being latched; load its
            // display time, then step to the next (row, plane) pair.
            load_cnt = 1'b1;
            if (shift_plane == PLANE_W'(PLANES - 1)) begin
               shift_plane_nx = '0;
               shift_row_nx   = shift_row + ADDR_W'(1);
               if (shift_row == '1) frame_tick_nx = 1'b1;
            end else begin
               shift_plane_nx = shift_plane + PLANE_W'(1);
            end
         end
         S_UNBLANK: begin
            led_blank_nx = 1'b0;
         end
         S_SHIFT, S_WAIT, S_DRAIN: begin
            // End the lit window as soon as the display time is used up,
            // even if the next shift is still running, so each plane keeps
            // its binary weight.
            if (disp_expire) led_blank_nx = 1'b1;
         end
         default: begin
         end
      endcase

      if (next_state == S_BLANK || next_state == S_IDLE) led_blank_nx = 1'b1;
   end

endmodule

// File: tb/tb_led_bcm_scheduler.sv
module tb_led_bcm_scheduler;
   import led_pkg::*;

   localparam int ADDR_W = 5;
   localparam int PLANES = 8;
   localparam int BASE   = 4;
   localparam int CNT_W  = 16;
   localparam int ROWS   = 1 << ADDR_W;
   localparam int SLOTS  = ROWS * PLANES;
   localparam int W      = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic drv_done = 1'b0;
   logic spur_done = 1'b0;
   logic shift_done;
   logic shift_req;
   logic [ADDR_W-1:0] shift_row;
   logic [2:0] shift_plane;
   logic [ADDR_W-1:0] led_addr;
   logic led_blank, led_latch, frame_tick;
   logic [ST_W-1:0] state;
`ifdef LED_BCM_SCHEDULER_BRIGHTNESS_EN
   logic [7:0] brightness = 8'hFF;
`endif

   assign shift_done = drv_done | spur_done;

   always #5 clk = ~clk;

   led_bcm_scheduler #(
      .ADDR_W (ADDR_W), .PLANES (PLANES), .BASE_CYCLES (BASE), .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .shift_req   (shift_req),
      .shift_done  (shift_done),
      .shift_row   (shift_row),
      .shift_plane (shift_plane),
      .led_addr    (led_addr),
      .led_blank   (led_blank),
      .led_latch   (led_latch),
      .frame_tick  (frame_tick),
`ifdef LED_BCM_SCHEDULER_BRIGHTNESS_EN
      .brightness  (brightness),
`endif
      .state       (state)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];   // {shift cycles[15:8], row[7:3], plane[2:0]}
   int model_k = 0;          // reference: index of the next slot to shift
   bit shifter_on = 0;
   bit shifter_busy = 0;
   int d_fixed = 63;         // >=0: fixed done delay, <0: random mix
   int latches = 0;
   int ticks = 0;
   int exp_ticks = 0;
   int cyc = 0;

   function automatic int slot_time(input int p);
      return BASE * (1 << p);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_latches(input int target, input int budget);
      for (int i = 0; i < budget && latches < target; i++) @(negedge clk);
      if (latches < target) check("latch_timeout", latches, target);
   endtask

   // ---------------- driver: the row shifter ----------------
   initial begin : shifter
      forever begin
         @(negedge clk);
         if (shifter_on && shift_req && !reset) begin
            int d;
            int row;
            int plane;
            shifter_busy = 1;
            row   = model_k / PLANES;
            plane = model_k % PLANES;
            check("shift_row", shift_row, row);
            check("shift_plane", shift_plane, plane);
            if (d_fixed >= 0) d = d_fixed;
            else if ($urandom_range(7, 0) == 0) d = $urandom_range(40, 0);
            else d = 0;
            exp_q.push_back({8'(d + 1), 5'(row), 3'(plane)});
            model_k = (model_k + 1) % SLOTS;
            repeat (d) @(negedge clk);
            drv_done = 1'b1;
            @(negedge clk);
            drv_done = 1'b0;
            shifter_busy = 0;
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      int low_len;
      bit in_low;
      bit have_prev;
      int prev_plane;
      int last_cyc;
      bit tick_due;
      logic [W-1:0] rec;
      int want;
      low_len = 0; in_low = 0; have_prev = 0; prev_plane = 0;
      last_cyc = 0; tick_due = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            in_low = 0; low_len = 0; have_prev = 0; tick_due = 0;
         end else begin
            if (tick_due || frame_tick) begin
               check("frame_tick", frame_tick, tick_due);
               if (frame_tick) ticks++;
            end
            tick_due = 0;
            if (state == S_IDLE) have_prev = 0;
            if (led_latch) begin
               latches++;
               if (exp_q.size() == 0) begin
                  check("unexpected_latch", 1, 0);
               end else begin
                  rec = exp_q.pop_front();
                  check("latch_addr", led_addr, rec[7:3]);
                  check("latch_plane", shift_plane, rec[2:0]);
                  check("blank_at_latch", led_blank, 1);
                  if (have_prev) begin
                     want = slot_time(prev_plane);
                     if (int'(rec[15:8]) > want) want = int'(rec[15:8]);
                     check("slot_len", cyc - last_cyc, want + 3);
                  end
                  have_prev = 1;
                  last_cyc = cyc;
                  prev_plane = int'(rec[2:0]);
                  if (rec[7:3] == 5'(ROWS - 1) && rec[2:0] == 3'(PLANES - 1)) begin
                     tick_due = 1;
                     exp_ticks++;
                  end
               end
            end
            if (!led_blank) begin
               low_len++;
               in_low = 1;
            end else if (in_low) begin
               check("blank_low_width", low_len, slot_time(prev_plane));
               in_low = 0;
               low_len = 0;
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int l0;
      int req_seen;
      bit hit;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_shift_req", shift_req, 0);
      check("rst_blank", led_blank, 1);
      check("rst_latch", led_latch, 0);
      check("rst_addr", led_addr, 0);
      check("rst_row", shift_row, 0);
      check("rst_plane", shift_plane, 0);
      check("rst_tick", frame_tick, 0);
      check("rst_state", state, S_IDLE);
      reset = 1'b0;

      // slow shifter: done 64 cycles after each request
      enable = 1'b1;
      shifter_on = 1;
      wait_latches(10, 3000);

      // mostly immediate shifts across a full frame
      d_fixed = -1;
      wait_latches(300, 50000);

      // drop enable while displaying plane 5 (plane 6 already shifted)
      d_fixed = 0;
      hit = 0;
      for (int i = 0; i < 4000 && !hit; i++) begin
         @(negedge clk);
         if (state == S_WAIT && shift_plane == 3'd6) hit = 1;
      end
      check("reach_wait_plane5", hit, 1);
      enable = 1'b0;
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge clk);
         if (state == S_IDLE) hit = 1;
      end
      check("drain_to_idle", hit, 1);
      check("idle_blank", led_blank, 1);
      check("drain_queue_empty", exp_q.size(), 0);
      req_seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (shift_req) req_seen++;
      end
      check("no_req_after_drain", req_seen, 0);

      // spurious shift_done while idle
      l0 = latches;
      for (int i = 0; i < 3; i++) begin
         spur_done = 1'b1;
         @(negedge clk);
         spur_done = 1'b0;
         repeat ($urandom_range(4, 1)) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check("spur_state", state, S_IDLE);
      check("spur_no_latch", latches, l0);
      check("spur_no_req", shift_req, 0);

      // resume: scan continues where it stopped
      d_fixed = -1;
      enable = 1'b1;
      wait_latches(latches + 12, 6000);

      // reset in the middle of S_SHIFT
      shifter_on = 0;
      hit = 0;
      for (int i = 0; i < 4000 && !hit; i++) begin
         @(negedge clk);
         if (state == S_SHIFT && !shifter_busy) hit = 1;
      end
      check("reach_shift", hit, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_shift_req", shift_req, 0);
      check("arst_blank", led_blank, 1);
      check("arst_latch", led_latch, 0);
      check("arst_addr", led_addr, 0);
      check("arst_row", shift_row, 0);
      check("arst_plane", shift_plane, 0);
      check("arst_tick", frame_tick, 0);
      check("arst_state", state, S_IDLE);
      exp_q.delete();
      model_k = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      shifter_on = 1;
      wait_latches(latches + 10, 3000);

      // wind down
      enable = 1'b0;
      hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk);
         if (state == S_IDLE) hit = 1;
      end
      check("final_idle", hit, 1);
      check("final_queue_empty", exp_q.size(), 0);
      check("frame_tick_count", ticks, exp_ticks);
      check("frame_seen", exp_ticks > 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
